// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, LSU state encoding and byte-enable generation.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} lsu_state_t;

    function automatic logic [3:0] be_gen(input logic [2:0] funct3, input logic [1:0] a);
        return funct3 == F3_B ? 4'b0001 << a : funct3 == F3_H ? 4'b0011 << a : 4'hF;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: picks the addressed byte/half of a DMEM word and sign/zero-extends it.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_data,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_a,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_b;
    logic [15:0] w_h;

    assign w_b = i_data[{i_a, 3'b000} +: 8];
    assign w_h = i_a[1] ? i_data[31:16] : i_data[15:0];

    assign o_rdata = i_funct3 == F3_B  ? {{24{w_b[7]}}, w_b} :
                     i_funct3 == F3_BU ? {24'b0, w_b} :
                     i_funct3 == F3_H  ? {{16{w_h[15]}}, w_h} :
                     i_funct3 == F3_HU ? {16'b0, w_h} :
                     i_funct3 == F3_W  ? i_data : '0;

endmodule

// File: rtl/lsu_dmem.sv
// lsu_dmem: RV32I load/store unit bridging a valid/ready core port to a req/ack DMEM port.
// Define LSU_TIMEOUT_EN to abort an ACCESS after TIMEOUT cycles without d_ack.
module lsu_dmem
    import lsu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DMEM_DEPTH = 1024,
    parameter int TIMEOUT    = 15,
    localparam int DA_W      = $clog2(DMEM_DEPTH)
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [DA_W-1:0]   daddr,
    output logic [DATA_W-1:0] ddata_w,
    output logic              d_rw,
    output logic [3:0]        d_be,
    output logic              d_req,
    input  logic              d_ack,
    input  logic [DATA_W-1:0] ddata_r
);

    if (DATA_W != 32 || TIMEOUT < 1) begin : g_cfg
        $error("lsu_dmem: DATA_W must be 32 and TIMEOUT at least 1");
    end

    lsu_state_t        r_state;
    logic              r_we;
    logic [2:0]        r_f3;
    logic [1:0]        r_a;
    logic              w_fire, w_bad_f3, w_misal, w_oor, w_err, w_expire;
    logic [DATA_W-1:0] w_ld, w_wd;

    assign w_fire   = req_valid && req_ready;
    assign w_bad_f3 = req_we ? !(req_funct3 inside {F3_B, F3_H, F3_W})
                             : !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    assign w_misal  = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                      (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    // Word-index compare also covers any address bit above the DMEM window.
    assign w_oor    = (req_addr >> 2) >= ADDR_W'(DMEM_DEPTH);
    assign w_err    = w_bad_f3 || w_misal || w_oor;
    assign w_wd     = req_funct3[1:0] == 2'b00 ? {4{req_wdata[7:0]}} :
                      req_funct3[1:0] == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;

    lsu_load_align u_align (
        .i_data   (ddata_r),
        .i_funct3 (r_f3),
        .i_a      (r_a),
        .o_rdata  (w_ld)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1) < 4 ? 4 : $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] r_cnt;
    assign w_expire = r_cnt == CNT_W'(TIMEOUT - 1);
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) r_cnt <= '0;
        else          r_cnt <= (r_state == ACCESS && !d_ack && !w_expire) ? r_cnt + 1'b1 : '0;
    end
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state   <= IDLE;
            r_we      <= 1'b0;
            r_f3      <= '0;
            r_a       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            daddr     <= '0;
            ddata_w   <= '0;
            d_rw      <= 1'b0;
            d_be      <= '0;
            d_req     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_fire) begin
                    r_we      <= req_we;
                    r_f3      <= req_funct3;
                    r_a       <= req_addr[1:0];
                    daddr     <= req_addr[DA_W+1:2];
                    ddata_w   <= w_wd;
                    d_rw      <= req_we;
                    d_be      <= req_we ? be_gen(req_funct3, req_addr[1:0]) : 4'hF;
                    req_ready <= 1'b0;
                    if (w_err) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        r_state   <= RESP;
                    end else begin
                        d_req   <= 1'b1;
                        r_state <= ACCESS;
                    end
                end
                ACCESS: if (d_ack) begin
                    d_req     <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= r_we ? '0 : w_ld;
                    r_state   <= RESP;
                end else if (w_expire) begin
                    d_req     <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b1;
                    r_state   <= RESP;
                end
                default: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                    req_ready <= 1'b1;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_dmem.sv
// tb_lsu_dmem: directed scenario tests for lsu_dmem with hand-computed expectations.
module tb_lsu_dmem;

    logic        CLK = 1'b0, RESET_N = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, d_ack = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0, req_wdata = '0, ddata_r = '0;
    logic        req_ready, rsp_valid, rsp_err, d_rw, d_req;
    logic [31:0] rsp_rdata, ddata_w;
    logic [9:0]  daddr;
    logic [3:0]  d_be;
    int checks = 0, errors = 0;

    always #5 CLK = ~CLK;

    lsu_dmem dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .daddr(daddr), .ddata_w(ddata_w), .d_rw(d_rw), .d_be(d_be),
        .d_req(d_req), .d_ack(d_ack), .ddata_r(ddata_r)
    );

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        @(negedge CLK);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge CLK);
        #1 req_valid = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %h exp 1", req_ready); end
        checks++; if ({rsp_valid, rsp_err, d_req, d_rw} !== 4'b0) begin errors++; $display("FAIL rst_ctrl got %b exp 0000", {rsp_valid, rsp_err, d_req, d_rw}); end
        checks++; if ({rsp_rdata, ddata_w, daddr, d_be} !== '0) begin errors++; $display("FAIL rst_data got %h exp 0", {rsp_rdata, ddata_w, daddr, d_be}); end
        @(negedge CLK) RESET_N = 1'b1;
    endtask

    task automatic test_lb();
        ddata_r = 32'h80FF_1234; d_ack = 1'b1;
        issue(1'b0, 3'b000, 32'h003, 32'h0);
        @(negedge CLK);
        checks++; if (d_req !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL lb_c1 got req=%b rsp=%b exp req=1 rsp=0", d_req, rsp_valid); end
        checks++; if (daddr !== 10'd0 || d_be !== 4'hF || d_rw !== 1'b0) begin errors++; $display("FAIL lb_dmem got a=%h be=%h rw=%b exp a=0 be=f rw=0", daddr, d_be, d_rw); end
        @(negedge CLK);
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || d_req !== 1'b0) begin errors++; $display("FAIL lb_c2 got v=%b e=%b req=%b exp v=1 e=0 req=0", rsp_valid, rsp_err, d_req); end
        checks++; if (rsp_rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_rdata got %h exp ffffff80", rsp_rdata); end
        @(negedge CLK);
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL lb_c3 got v=%b rdy=%b exp v=0 rdy=1", rsp_valid, req_ready); end
    endtask

    task automatic test_sh();
        d_ack = 1'b1;
        issue(1'b1, 3'b001, 32'h00A, 32'h0000_BEEF);
        @(negedge CLK);
        checks++; if (d_req !== 1'b1 || d_rw !== 1'b1 || daddr !== 10'd2) begin errors++; $display("FAIL sh_ctl got req=%b rw=%b a=%h exp 1 1 2", d_req, d_rw, daddr); end
        checks++; if (d_be !== 4'b1100 || ddata_w !== 32'hBEEF_BEEF) begin errors++; $display("FAIL sh_lane got be=%b d=%h exp 1100 beefbeef", d_be, ddata_w); end
        @(negedge CLK);
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL sh_rsp got v=%b e=%b d=%h exp 1 0 0", rsp_valid, rsp_err, rsp_rdata); end
        d_ack = 1'b0;
    endtask

    task automatic test_errors();
        logic [35:0] vec [6] = '{{1'b0, 3'b010, 32'h0000_0006}, {1'b0, 3'b010, 32'h0000_1000},
                                 {1'b0, 3'b011, 32'h0000_0000}, {1'b1, 3'b100, 32'h0000_0000},
                                 {1'b0, 3'b001, 32'h0000_0001}, {1'b0, 3'b000, 32'h8000_0000}};
        d_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            issue(vec[i][35], vec[i][34:32], vec[i][31:0], 32'h1234_5678);
            @(negedge CLK);
            checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || d_req !== 1'b0 || rsp_rdata !== 32'h0) begin
                errors++; $display("FAIL err_rsp[%0d] got v=%b e=%b req=%b d=%h exp 1 1 0 0", i, rsp_valid, rsp_err, d_req, rsp_rdata); end
            @(negedge CLK);
            checks++; if (rsp_valid !== 1'b0 || d_req !== 1'b0 || req_ready !== 1'b1) begin
                errors++; $display("FAIL err_end[%0d] got v=%b req=%b rdy=%b exp 0 0 1", i, rsp_valid, d_req, req_ready); end
        end
    endtask

    task automatic test_wait();
        ddata_r = 32'hA5A5_0000; d_ack = 1'b0;
        issue(1'b0, 3'b101, 32'h002, 32'h0);
        for (int i = 1; i <= 5; i++) begin
            @(negedge CLK);
            checks++; if (d_req !== 1'b1 || daddr !== 10'd0 || d_be !== 4'hF || rsp_valid !== 1'b0) begin
                errors++; $display("FAIL wait_hold[%0d] got req=%b a=%h be=%h v=%b exp 1 0 f 0", i, d_req, daddr, d_be, rsp_valid); end
            if (i == 5) d_ack = 1'b1;
        end
        @(negedge CLK);
        d_ack = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || d_req !== 1'b0 || rsp_rdata !== 32'h0000_A5A5) begin
            errors++; $display("FAIL wait_rsp got v=%b req=%b d=%h exp 1 0 0000a5a5", rsp_valid, d_req, rsp_rdata); end
    endtask

    task automatic test_back_to_back();
        logic [66:0] vec [5] = '{{3'b100, 32'h005, 32'h0000_C300}, {3'b010, 32'h004, 32'h80FF_1234},
                                 {3'b001, 32'h006, 32'h80FF_1234}, {3'b000, 32'h000, 32'h80FF_1234},
                                 {3'b101, 32'h000, 32'h0000_8001}};
        logic [31:0] exp [5] = '{32'h0000_00C3, 32'h80FF_1234, 32'hFFFF_80FF, 32'h0000_0034, 32'h0000_8001};
        logic [31:0] a;
        d_ack = 1'b1;
        issue(1'b1, 3'b000, 32'h001, 32'h1234_5678);
        @(negedge CLK);
        checks++; if (d_be !== 4'b0010 || ddata_w !== 32'h7878_7878 || d_rw !== 1'b1) begin
            errors++; $display("FAIL sb_lane got be=%b d=%h rw=%b exp 0010 78787878 1", d_be, ddata_w, d_rw); end
        @(negedge CLK);
        for (int i = 0; i < 5; i++) begin
            a = vec[i][63:32];
            ddata_r = vec[i][31:0];
            issue(1'b0, vec[i][66:64], a, 32'h0);
            @(negedge CLK);
            checks++; if (daddr !== a[11:2] || d_rw !== 1'b0) begin errors++; $display("FAIL b2b_addr[%0d] got %h exp %h", i, daddr, a[11:2]); end
            @(negedge CLK);
            checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== exp[i]) begin
                errors++; $display("FAIL b2b_rdata[%0d] got v=%b d=%h exp 1 %h", i, rsp_valid, rsp_rdata, exp[i]); end
        end
        d_ack = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_timeout();
        int  n = 0;
        bit  seen = 1'b0;
        d_ack = 1'b0;
        issue(1'b0, 3'b010, 32'h010, 32'h0);
`ifdef LSU_TIMEOUT_EN
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge CLK);
            if (rsp_valid) seen = 1'b1;
            else if (d_req) n++;
        end
        checks++; if (seen !== 1'b1 || n != 15) begin errors++; $display("FAIL to_cycles got seen=%b n=%0d exp 1 15", seen, n); end
        checks++; if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0 || d_req !== 1'b0) begin
            errors++; $display("FAIL to_rsp got e=%b d=%h req=%b exp 1 0 0", rsp_err, rsp_rdata, d_req); end
        @(negedge CLK);
`else
        repeat (100) begin
            @(negedge CLK);
            if (rsp_valid) seen = 1'b1;
            if (d_req) n++;
        end
        checks++; if (seen !== 1'b0 || n != 100) begin errors++; $display("FAIL nto_wait got seen=%b n=%0d exp 0 100", seen, n); end
        ddata_r = 32'h0BAD_F00D; d_ack = 1'b1;
        @(negedge CLK);
        d_ack = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0BAD_F00D) begin
            errors++; $display("FAIL nto_rsp got v=%b e=%b d=%h exp 1 0 0badf00d", rsp_valid, rsp_err, rsp_rdata); end
        @(negedge CLK);
`endif
    endtask

    task automatic test_reset_mid();
        d_ack = 1'b0;
        issue(1'b0, 3'b010, 32'h020, 32'h0);
        @(negedge CLK);
        checks++; if (d_req !== 1'b1) begin errors++; $display("FAIL rm_pre got %b exp 1", d_req); end
        #2 RESET_N = 1'b0;
        #1;
        checks++; if (d_req !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rm_async got req=%b rdy=%b exp 0 1", d_req, req_ready); end
        @(negedge CLK) RESET_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || d_req !== 1'b0) begin
                errors++; $display("FAIL rm_after[%0d] got v=%b rdy=%b req=%b exp 0 1 0", i, rsp_valid, req_ready, d_req); end
        end
    endtask

    initial begin
        test_reset();
        test_lb();
        test_sh();
        test_errors();
        test_wait();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
